display_scan_driver: RTL and testbench



---
 rtl/display_pkg.sv | 10 +
 rtl/hex7seg.sv | 9 +
 rtl/display_scan_driver.sv | 76 +++++++
 tb/tb_display_scan_driver.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared segment types, blank pattern and hex-to-segment table for the scan driver
package display_pkg;
  typedef logic [6:0] seg_t;
  typedef enum logic {BLANK, SHOW} phase_t;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex nibble to active-low gfedcba segment lookup
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);
  assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver: time-multiplexed 7-segment scanner with per-slot blanking and per-frame input snapshot
module display_scan_driver
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   dp_mask,
  output logic [N_DIGITS-1:0]   an,
  output seg_t                  seg,
  output logic                  dp,
  output logic                  frame_tick
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);
  if (N_DIGITS < 2 || SLOT_CYCLES < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_params
    $error("display_scan_driver: illegal N_DIGITS/SLOT_CYCLES/BLANK_CYCLES");
  end
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  phase_t state, state_nxt;
  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0] snap_en, snap_dp, an_nxt;
  seg_t hex_seg, seg_nxt;
  logic dp_nxt, frame_start, lit;
  hex7seg u_hex7seg (
    .hex(snap_digits[{idx, 2'b00} +: 4]),
    .seg(hex_seg)
  );
  always_comb begin
    frame_start = cnt == '0 && idx == '0;
    cnt_nxt = cnt == CNT_MAX ? '0 : cnt + 1'b1;
    idx_nxt = cnt != CNT_MAX ? idx : idx == IDX_MAX ? '0 : idx + 1'b1;
    state_nxt = cnt_nxt < CNT_BLANK ? BLANK : SHOW;
    lit = state == SHOW && snap_en[idx];
    an_nxt = lit ? ~(AN_ONE << (IDX_MAX - idx)) : '1;
    seg_nxt = lit ? hex_seg : SEG_BLANK;
    dp_nxt = ~(lit && snap_dp[idx]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      state <= BLANK;
      snap_digits <= '0;
      snap_en <= '0;
      snap_dp <= '0;
      an <= '1;
      seg <= SEG_BLANK;
      dp <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      state <= state_nxt;
      an <= an_nxt;
      seg <= seg_nxt;
      dp <= dp_nxt;
      frame_tick <= frame_start;
      if (frame_start) begin
        snap_digits <= digits;
        snap_en <= digit_en;
        snap_dp <= dp_mask;
      end
    end
  end
endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver: scoreboard bench for directed scan sequences plus long-run scan invariants
module tb_display_scan_driver;
  import display_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [15:0] digits;
  logic [3:0] digit_en, dp_mask, an;
  seg_t seg;
  logic dp, frame_tick;
  logic r6;
  logic [15:0] d6;
  logic [3:0] e6, m6, an6;
  seg_t seg6;
  logic dp6, ft6;
  display_scan_driver #(.N_DIGITS(4), .SLOT_CYCLES(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .digits(digits), .digit_en(digit_en), .dp_mask(dp_mask),
    .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );
  display_scan_driver #(.N_DIGITS(4), .SLOT_CYCLES(8), .BLANK_CYCLES(3)) dut6 (
    .clk(clk), .reset(r6), .digits(d6), .digit_en(e6), .dp_mask(m6),
    .an(an6), .seg(seg6), .dp(dp6), .frame_tick(ft6)
  );
  typedef struct {
    string name;
    logic [3:0] an;
    seg_t seg;
    logic dp;
    logic ft;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  int tests = 0;
  int fails = 0;
  string tag;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      cur = q.pop_front();
      tests++;
      if ({an, seg, dp, frame_tick} !== {cur.an, cur.seg, cur.dp, cur.ft}) begin
        fails++;
        $display("FAIL %s @%0t: got an=%b seg=%h dp=%b ft=%b, want an=%b seg=%h dp=%b ft=%b",
                 cur.name, $time, an, seg, dp, frame_tick, cur.an, cur.seg, cur.dp, cur.ft);
      end
    end
  end
  task automatic step(input logic [3:0] a, input seg_t s, input logic d, input logic f);
    exp_t e;
    e.name = tag;
    e.an = a;
    e.seg = s;
    e.dp = d;
    e.ft = f;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic blank(input logic f);
    step(4'hF, SEG_BLANK, 1'b1, f);
  endtask
  task automatic slot(input logic [3:0] a, input seg_t s, input logic d, input logic f);
    blank(f);
    repeat (3) step(a, s, d, 1'b0);
  endtask
  task automatic run_main();
    tag = "reset";
    reset = 1'b1;
    digits = 16'h1234;
    digit_en = 4'hF;
    dp_mask = 4'hF;
    repeat (3) blank(1'b0);
    tag = "scan";
    reset = 1'b0;
    digits = 16'h4321;
    dp_mask = 4'h0;
    slot(4'b0111, 7'h79, 1'b1, 1'b1);
    blank(1'b0);
    step(4'b1011, 7'h24, 1'b1, 1'b0);
    digits = 16'hFFFF;
    tag = "snapshot";
    step(4'b1011, 7'h24, 1'b1, 1'b0);
    step(4'b1011, 7'h24, 1'b1, 1'b0);
    slot(4'b1101, 7'h30, 1'b1, 1'b0);
    slot(4'b1110, 7'h19, 1'b1, 1'b0);
    slot(4'b0111, 7'h0E, 1'b1, 1'b1);
    slot(4'b1011, 7'h0E, 1'b1, 1'b0);
    digits = 16'h0A05;
    digit_en = 4'b0101;
    dp_mask = 4'b0001;
    slot(4'b1101, 7'h0E, 1'b1, 1'b0);
    slot(4'b1110, 7'h0E, 1'b1, 1'b0);
    tag = "masks";
    slot(4'b0111, 7'h12, 1'b0, 1'b1);
    slot(4'hF, SEG_BLANK, 1'b1, 1'b0);
    slot(4'b1101, 7'h08, 1'b1, 1'b0);
    slot(4'hF, SEG_BLANK, 1'b1, 1'b0);
    tag = "midreset";
    slot(4'b0111, 7'h12, 1'b0, 1'b1);
    slot(4'hF, SEG_BLANK, 1'b1, 1'b0);
    blank(1'b0);
    step(4'b1101, 7'h08, 1'b1, 1'b0);
    reset = 1'b1;
    blank(1'b0);
    blank(1'b0);
    reset = 1'b0;
    tag = "restart";
    slot(4'b0111, 7'h12, 1'b0, 1'b1);
    slot(4'hF, SEG_BLANK, 1'b1, 1'b0);
  endtask
  task automatic run_long();
    int lit [4];
    logic [3:0] cap;
    cap = '0;
    r6 = 1'b1;
    d6 = '0;
    e6 = '0;
    m6 = '0;
    repeat (2) @(posedge clk);
    #1;
    r6 = 1'b0;
    for (int n = 1; n <= 992; n++) begin
      d6 = 16'($urandom);
      e6 = 4'($urandom);
      m6 = 4'($urandom);
      if (n % 32 == 1) begin
        cap = e6;
        for (int i = 0; i < 4; i++) lit[i] = 0;
      end
      @(posedge clk);
      #1;
      tests++;
      if ($countones(~an6) > 1) begin
        fails++;
        $display("FAIL long_onehot cycle %0d: got an=%b, want at most one low", n, an6);
      end
      tests++;
      if (ft6 !== (n % 32 == 1)) begin
        fails++;
        $display("FAIL long_tick cycle %0d: got %b, want %b", n, ft6, n % 32 == 1);
      end
      tests++;
      if (an6 == 4'hF && {seg6, dp6} !== {SEG_BLANK, 1'b1}) begin
        fails++;
        $display("FAIL long_dark cycle %0d: got seg=%h dp=%b, want seg=7f dp=1", n, seg6, dp6);
      end
      for (int i = 0; i < 4; i++) if (!an6[3-i]) lit[i]++;
      if (n % 32 == 0) begin
        for (int i = 0; i < 4; i++) begin
          tests++;
          if (lit[i] != (cap[i] ? 5 : 0)) begin
            fails++;
            $display("FAIL long_lit frame %0d digit %0d: got %0d cycles, want %0d", n / 32, i, lit[i], cap[i] ? 5 : 0);
          end
        end
      end
    end
  endtask
  initial begin
    #1;
    fork
      run_main();
      run_long();
    join
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end
endmodule
